mul_issue_sched: RTL and testbench

- Issue scheduler in front of the two-stage integer multiplier in the exe stage.
- Buffers multiply requests from the issue queue in a 2-entry FIFO and releases one per cycle to the multiplier.
- The multiplier has variable latency: 32-bit ops write back 1 cycle after issue, 64-bit ops after 2, and it shares its writeback port with the divider.
- The scheduler tracks reserved writeback slots so that no two results ever reach the writeback port in the same cycle.

---
 rtl/drac_pkg.sv | 14 +
 rtl/mul_sched_fifo.sv | 59 +++++
 rtl/mul_issue_sched.sv | 142 ++++++++++++++
 tb/tb_mul_issue_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared multiplier issue-scheduler types and latency constants.
// Imported by the scheduler top and its request FIFO.
package drac_pkg;

  localparam int MUL_LAT_32 = 1;
  localparam int MUL_LAT_64 = 2;
  localparam int MUL_TAG_W  = 7;

  typedef struct packed {
    logic                 op32;
    logic [MUL_TAG_W-1:0] tag;
  } mul_sched_req_t;

endpackage

// File: rtl/mul_sched_fifo.sv
// Two-entry in-order request FIFO with synchronous flush.
// Push while full is accepted only together with a pop.
module mul_sched_fifo
  import drac_pkg::*;
#(
  parameter type T = mul_sched_req_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic empty_o,
  output logic full_o
);

  T           mem_q [2];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] cnt_q;
  logic       wr;
  logic       rd;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign rd      = pop_i & ~empty_o;
  assign wr      = push_i & (~full_o | rd);
  assign data_o  = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (wr) wptr_q <= ~wptr_q;
      if (rd) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, wr} - {1'b0, rd};
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (wr && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mul_issue_sched.sv
// Multiplier issue scheduler: FIFO + writeback slot reservation.
// Optional MUL_SCHED_PERF_EN adds saturating stall/issue counters.
module mul_issue_sched
  import drac_pkg::*;
#(
  parameter int LAT_32 = MUL_LAT_32,
  parameter int LAT_64 = MUL_LAT_64,
  parameter int TAG_W  = MUL_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_op32_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             div_wb_soon_i,
  output logic             mul_valid_o,
  output logic             mul_op32_o,
  output logic [TAG_W-1:0] mul_tag_o,
  output logic             busy_o
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_hazard_cnt_o,
  output logic [31:0]      stall_div_cnt_o,
  output logic [31:0]      issue_cnt_o
`endif
);

  typedef struct packed {
    logic             op32;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t            in_req;
  req_t            head;
  logic            head_empty;
  logic            fifo_full;
  logic            head_valid;
  logic            push;
  logic            issue;
  logic            mul_hit;
  logic            div_hit;
  logic [LAT_64:1] mul_slot_q;
  logic [LAT_64:1] div_slot_q;
  logic [LAT_64:1] mul_sh;
  logic [LAT_64:1] div_sh;
  logic [LAT_64:1] mul_d;
  logic [LAT_64:1] div_d;
  int              lat;

  assign in_req.op32 = req_op32_i;
  assign in_req.tag  = req_tag_i;
  assign req_ready_o = ~fifo_full;
  assign push        = req_valid_i & req_ready_o & ~flush_i;
  assign head_valid  = ~head_empty;
  assign mul_valid_o = issue;
  assign mul_op32_o  = head.op32;
  assign mul_tag_o   = head.tag;
  assign busy_o      = head_valid | (|mul_slot_q);

  mul_sched_fifo #(
    .T(req_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (issue),
    .data_i  (in_req),
    .data_o  (head),
    .empty_o (head_empty),
    .full_o  (fifo_full)
  );

  // Age slots by one cycle, then test the head's writeback slot.
  always_comb begin
    mul_sh  = '0;
    div_sh  = '0;
    mul_hit = 1'b0;
    div_hit = 1'b0;
    lat     = head.op32 ? LAT_32 : LAT_64;
    for (int k = 1; k < LAT_64; k++) begin
      mul_sh[k] = mul_slot_q[k+1];
      div_sh[k] = div_slot_q[k+1];
    end
    for (int k = 1; k <= LAT_64; k++) begin
      if (k == lat) begin
        mul_hit = mul_sh[k];
        div_hit = div_sh[k] | (div_wb_soon_i && k == 1);
      end
    end
    issue = head_valid & ~flush_i & ~mul_hit & ~div_hit;
  end

  // Apply new reservations on top of the aged vectors.
  always_comb begin
    mul_d = mul_sh;
    div_d = div_sh;
    for (int k = 1; k <= LAT_64; k++) begin
      if (issue && k == lat) mul_d[k] = 1'b1;
    end
    if (div_wb_soon_i) div_d[1] = 1'b1;
    if (flush_i) mul_d = '0;
  end

  // Slot vector state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mul_slot_q <= '0;
      div_slot_q <= '0;
    end else begin
      mul_slot_q <= mul_d;
      div_slot_q <= div_d;
    end
  end

`ifdef MUL_SCHED_PERF_EN
  logic stall_hz;
  logic stall_dv;

  assign stall_hz = head_valid & ~flush_i & mul_hit;
  assign stall_dv = head_valid & ~flush_i & div_hit;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_hazard_cnt_o <= '0;
      stall_div_cnt_o    <= '0;
      issue_cnt_o        <= '0;
    end else begin
      if (stall_hz && stall_hazard_cnt_o != '1)
        stall_hazard_cnt_o <= stall_hazard_cnt_o + 32'd1;
      if (stall_dv && stall_div_cnt_o != '1)
        stall_div_cnt_o <= stall_div_cnt_o + 32'd1;
      if (issue && issue_cnt_o != '1)
        issue_cnt_o <= issue_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_sched.sv
// Bench for mul_issue_sched: directed scenarios plus random
// traffic against an absolute-time writeback reservation model.
module tb_mul_issue_sched;

  localparam int TW = 7;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_op32_i = 1'b0;
  logic [TW-1:0] req_tag_i = '0;
  logic          div_wb_soon_i = 1'b0;
  logic          mul_valid_o;
  logic          mul_op32_o;
  logic [TW-1:0] mul_tag_o;
  logic          busy_o;

  mul_issue_sched dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op32_i    (req_op32_i),
    .req_tag_i     (req_tag_i),
    .div_wb_soon_i (div_wb_soon_i),
    .mul_valid_o   (mul_valid_o),
    .mul_op32_o    (mul_op32_o),
    .mul_tag_o     (mul_tag_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit       op32;
    bit [6:0] tag;
  } mreq_t;

  int    n_chk = 0;
  int    n_pass = 0;
  mreq_t mq[$];
  int    mul_t[$];
  int    div_t[$];
  int    cyc = 0;
  bit    iss;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit has(input int q[$], input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive inputs, compare outputs with model, update model.
  task automatic step(input bit v, input bit op, input bit [6:0] tg,
                      input bit dv, input bit fl, output bit is);
    int    tgt;
    bit    rdy;
    mreq_t r;
    @(negedge clk_i);
    req_valid_i   = v;
    req_op32_i    = op;
    req_tag_i     = tg;
    div_wb_soon_i = dv;
    flush_i       = fl;
    #1;
    mul_t = mul_t.find with (item >= cyc);
    div_t = div_t.find with (item >= cyc);
    is  = 1'b0;
    tgt = 0;
    rdy = mq.size() < 2;
    if (mq.size() > 0 && !fl) begin
      tgt = cyc + (mq[0].op32 ? 1 : 2);
      is  = !has(mul_t, tgt) && !has(div_t, tgt)
            && !(dv && tgt == cyc + 1);
    end
    chk("valid", mul_valid_o, is);
    if (is) begin
      chk("tag", mul_tag_o, mq[0].tag);
      chk("op32", mul_op32_o, mq[0].op32);
    end
    chk("ready", req_ready_o, rdy);
    chk("busy", busy_o, (mq.size() > 0) || (mul_t.size() > 0));
    if (is) begin
      mul_t.push_back(tgt);
      void'(mq.pop_front());
    end
    if (dv) div_t.push_back(cyc + 1);
    if (fl) begin
      mul_t.delete();
      mq.delete();
    end else if (v && rdy) begin
      r.op32 = op;
      r.tag  = tg;
      mq.push_back(r);
    end
    cyc++;
  endtask

  task automatic do_reset();
    req_valid_i   = 1'b0;
    flush_i       = 1'b0;
    div_wb_soon_i = 1'b0;
    #3 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_valid", mul_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_mslot", dut.mul_slot_q, 0);
    chk("rst_dslot", dut.div_slot_q, 0);
    rst_i = 1'b0;
    mq.delete();
    mul_t.delete();
    div_t.delete();
    cyc = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, iss);
  endtask

  initial begin
    do_reset();

    // 64-bit then 32-bit: the 32-bit op stalls one cycle.
    step(1, 0, 7'h01, 0, 0, iss);
    step(1, 1, 7'h02, 0, 0, iss);
    chk("b2b_t0", mul_valid_o, 1);
    step(0, 0, 0, 0, 0, iss);
    chk("b2b_t1", mul_valid_o, 0);
    step(0, 0, 0, 0, 0, iss);
    chk("b2b_t2", mul_valid_o, 1);
    chk("b2b_tag", mul_tag_o, 7'h02);
    idle(3);

    // Four consecutive 64-bit ops issue every cycle.
    step(1, 0, 7'h0a, 0, 0, iss);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 7'(8'h0b + i), 0, 0, iss);
      chk("seq64_v", mul_valid_o, 1);
      chk("seq64_r", req_ready_o, 1);
    end
    step(0, 0, 0, 0, 0, iss);
    chk("seq64_last", mul_valid_o, 1);
    idle(3);

    // Divider reservation blocks a 32-bit head but not a 64-bit one.
    step(1, 1, 7'h03, 0, 0, iss);
    step(0, 0, 0, 1, 0, iss);
    chk("div32_t0", mul_valid_o, 0);
    step(0, 0, 0, 0, 0, iss);
    chk("div32_t1", mul_valid_o, 1);
    idle(2);
    step(1, 0, 7'h04, 0, 0, iss);
    step(0, 0, 0, 1, 0, iss);
    chk("div64_t0", mul_valid_o, 1);
    idle(3);

    // Flush with two queued entries and a 64-bit op in flight.
    step(1, 0, 7'h05, 0, 0, iss);
    step(1, 1, 7'h06, 0, 0, iss);
    step(1, 1, 7'h07, 0, 0, iss);
    step(0, 0, 0, 1, 1, iss);
    chk("fl_valid", mul_valid_o, 0);
    step(0, 0, 0, 0, 0, iss);
    chk("fl_busy", busy_o, 0);
    chk("fl_ready", req_ready_o, 1);
    chk("fl_mslot", dut.mul_slot_q, 0);
    chk("fl_dslot", dut.div_slot_q[1], 1);
    idle(2);

    // Fill the FIFO behind a div-blocked head; tag order preserved.
    step(1, 1, 7'h11, 1, 0, iss);
    step(1, 1, 7'h22, 1, 0, iss);
    step(1, 1, 7'h33, 1, 0, iss);
    chk("full_ready", req_ready_o, 0);
    step(1, 1, 7'h33, 0, 0, iss);
    chk("ord_11", mul_tag_o, 7'h11);
    chk("hold_ready", req_ready_o, 0);
    step(1, 1, 7'h33, 0, 0, iss);
    chk("ord_22", mul_tag_o, 7'h22);
    step(0, 0, 0, 0, 0, iss);
    chk("ord_33", mul_tag_o, 7'h33);
    idle(3);

    // Random traffic with a reset dropped in mid-run.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
           7'($urandom), $urandom_range(3, 0) == 0,
           $urandom_range(15, 0) == 0, iss);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
